// File: rtl/compress_sched.sv
// Block scheduler: round-robin feed into the compression pipeline,
// tag FIFO across its latency, and a 1/2-line write-back FSM.
module compress_sched #(
    parameter int MAX_INFLIGHT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][1023:0]     req_pixels,
    output logic [1:0]             req_ready,
    output logic                   pipe_in_valid,
    output logic [1023:0]          pipe_in_pixels,
    input  logic                   pipe_in_ready,
    input  logic                   commit_valid,
    input  logic                   commit_compressable,
    input  logic [511:0]           commit_l1,
    input  logic [511:0]           commit_l2,
    output logic                   commit_ready,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [511:0]           mem_wdata,
    input  logic                   mem_resp,
    output logic [1:0]             done,
    output logic                   done_compressed,
    output logic                   busy,
    output logic                   err
);

    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WR_L1, WR_L2, RESP} state_t;

    state_t            state_q;
    logic              rst_q;
    logic              last_q;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic              id_mem [MAX_INFLIGHT];
    logic [ADDR_W-1:0] addr_mem [MAX_INFLIGHT];
    logic              tag_id_q;
    logic [ADDR_W-1:0] tag_addr_q;
    logic [511:0]      l1_q, l2_q;
    logic              cmp_q;
    logic              err_q;

    logic out_ok, gnt, push, pop, wr_st;

    // Outputs stay quiet through reset and the first cycle after it.
    assign out_ok = ~rst & ~rst_q;
    assign gnt = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    assign pipe_in_valid  = out_ok & (|req_valid)
                          & (count_q < CW'(MAX_INFLIGHT));
    assign pipe_in_pixels = req_pixels[gnt];
    assign push           = pipe_in_valid & pipe_in_ready;
    assign req_ready      = push ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    assign commit_ready = out_ok & (state_q == IDLE) & (count_q != '0);
    assign pop          = commit_valid & commit_ready;

    assign wr_st     = (state_q == WR_L1) | (state_q == WR_L2);
    assign mem_write = out_ok & wr_st;
    assign mem_addr  = (state_q == WR_L2) ? tag_addr_q + ADDR_W'(64)
                                          : tag_addr_q;
    assign mem_wdata = (state_q == WR_L2) ? l2_q : l1_q;

    assign done = (out_ok && state_q == RESP)
                ? (tag_id_q ? 2'b10 : 2'b01) : 2'b00;
    assign done_compressed = out_ok & (state_q == RESP) & cmp_q;
    assign busy = out_ok & ((count_q != '0) | (state_q != IDLE));
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_q]   <= gnt;
            addr_mem[wr_ptr_q] <= req_addr[gnt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rst_q      <= 1'b1;
            last_q     <= 1'b1;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            tag_id_q   <= 1'b0;
            tag_addr_q <= '0;
            l1_q       <= '0;
            l2_q       <= '0;
            cmp_q      <= 1'b0;
        end else begin
            rst_q <= 1'b0;
            if (commit_valid && count_q == '0)
                err_q <= 1'b1;
            if (push) begin
                last_q   <= gnt;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
            unique case (state_q)
                IDLE: if (pop) begin
                    l1_q       <= commit_l1;
                    l2_q       <= commit_l2;
                    cmp_q      <= commit_compressable;
                    tag_id_q   <= id_mem[rd_ptr_q];
                    tag_addr_q <= addr_mem[rd_ptr_q];
                    state_q    <= WR_L1;
                end
                WR_L1: if (mem_resp)
                    state_q <= cmp_q ? RESP : WR_L2;
                WR_L2: if (mem_resp)
                    state_q <= RESP;
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compress_sched.sv
// Directed bench for compress_sched: single/dual-line writes,
// fairness, FIFO full, address wrap, error flag, mid-write reset.
module tb_compress_sched;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_addr;
    logic [1:0][1023:0] req_pixels;
    logic [1:0]       req_ready;
    logic             pipe_in_valid;
    logic [1023:0]    pipe_in_pixels;
    logic             pipe_in_ready;
    logic             commit_valid;
    logic             commit_compressable;
    logic [511:0]     commit_l1;
    logic [511:0]     commit_l2;
    logic             commit_ready;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [511:0]     mem_wdata;
    logic             mem_resp;
    logic [1:0]       done;
    logic             done_compressed;
    logic             busy;
    logic             err;

    int n_vec;
    int n_bad;

    compress_sched #(.MAX_INFLIGHT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_pixels(req_pixels), .req_ready(req_ready),
        .pipe_in_valid(pipe_in_valid),
        .pipe_in_pixels(pipe_in_pixels),
        .pipe_in_ready(pipe_in_ready),
        .commit_valid(commit_valid),
        .commit_compressable(commit_compressable),
        .commit_l1(commit_l1), .commit_l2(commit_l2),
        .commit_ready(commit_ready),
        .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .done(done), .done_compressed(done_compressed),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [511:0] got,
                         input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int r, input logic [31:0] a,
                          input logic [1023:0] px);
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        req_valid = oh;
        req_addr[r] = a;
        req_pixels[r] = px;
        pipe_in_ready = 1'b1;
        #1;
        check("acc_vld", 512'(pipe_in_valid), 512'(1));
        check("acc_rdy", 512'(req_ready), 512'(oh));
        check("acc_pix_lo", pipe_in_pixels[511:0], px[511:0]);
        check("acc_pix_hi", pipe_in_pixels[1023:512], px[1023:512]);
        tick();
        req_valid = 2'b00;
        pipe_in_ready = 1'b0;
    endtask

    task automatic commit(input logic c, input logic [511:0] l1,
                          input logic [511:0] l2);
        commit_valid = 1'b1;
        commit_compressable = c;
        commit_l1 = l1;
        commit_l2 = l2;
        #1;
        check("cmt_rdy", 512'(commit_ready), 512'(1));
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic write_line(input logic [31:0] a,
                              input logic [511:0] d);
        check("wr_en", 512'(mem_write), 512'(1));
        check("wr_addr", 512'(mem_addr), 512'(a));
        check("wr_data", mem_wdata, d);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
    endtask

    task automatic done_chk(input logic [1:0] d, input logic c);
        check("done", 512'(done), 512'(d));
        check("done_cmp", 512'(done_compressed), 512'(c));
        check("done_nowr", 512'(mem_write), 512'(0));
        tick();
        check("done_gone", 512'(done), 512'(0));
    endtask

    logic [1023:0] px0, px1;
    logic [511:0]  la, lb, lc;
    logic [31:0]   fa [4];
    logic [1:0]    fd [4];

    initial begin
        n_vec = 0;
        n_bad = 0;
        px0 = {32{32'hA0A1A2A3}};
        px1 = {32{32'h5B5C5D5E}};
        la  = {16{32'h11112222}};
        lb  = {16{32'h33334444}};
        lc  = {16{32'h55556666}};
        rst = 1'b1;
        req_valid = 2'b11;
        req_addr = '0;
        req_pixels = '0;
        pipe_in_ready = 1'b1;
        commit_valid = 1'b0;
        commit_compressable = 1'b0;
        commit_l1 = '0;
        commit_l2 = '0;
        mem_resp = 1'b0;

        tick();
        tick();
        check("rst_pvld", 512'(pipe_in_valid), 512'(0));
        check("rst_rdy", 512'(req_ready), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_crdy", 512'(commit_ready), 512'(0));
        check("rst_err", 512'(err), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        rst = 1'b0;
        #1;
        check("post_pvld", 512'(pipe_in_valid), 512'(0));
        check("post_rdy", 512'(req_ready), 512'(0));
        tick();
        pipe_in_ready = 1'b0;
        #1;
        check("live_pvld", 512'(pipe_in_valid), 512'(1));
        check("live_busy", 512'(busy), 512'(0));
        req_valid = 2'b00;
        tick();

        // single compressable block
        accept(0, 32'h0000_1000, px0);
        check("t1_busy", 512'(busy), 512'(1));
        commit(1'b1, la, lb);
        check("t1_crdy0", 512'(commit_ready), 512'(0));
        check("t1_hold", 512'(mem_write), 512'(1));
        tick();
        write_line(32'h0000_1000, la);
        done_chk(2'b01, 1'b1);
        check("t1_idle", 512'(busy), 512'(0));

        // uncompressable block, two lines
        accept(1, 32'h0000_2040, px1);
        commit(1'b0, lb, lc);
        write_line(32'h0000_2040, lb);
        write_line(32'h0000_2080, lc);
        done_chk(2'b10, 1'b0);

        // fairness and full FIFO
        req_addr[0] = 32'h0000_3000;
        req_addr[1] = 32'h0000_3040;
        req_pixels[0] = px0;
        req_pixels[1] = px1;
        req_valid = 2'b11;
        pipe_in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_rdy", 512'(req_ready),
                  512'((i % 2 == 0) ? 2'b01 : 2'b10));
            check("rr_pix", pipe_in_pixels[511:0],
                  (i % 2 == 0) ? px0[511:0] : px1[511:0]);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            check("full_pvld", 512'(pipe_in_valid), 512'(0));
            check("full_rdy", 512'(req_ready), 512'(0));
            tick();
        end
        commit(1'b1, la, lb);
        pipe_in_ready = 1'b0;
        #1;
        check("unfull_pvld", 512'(pipe_in_valid), 512'(1));
        req_valid = 2'b00;
        fa[0] = 32'h0000_3000; fd[0] = 2'b01;
        fa[1] = 32'h0000_3040; fd[1] = 2'b10;
        fa[2] = 32'h0000_3000; fd[2] = 2'b01;
        fa[3] = 32'h0000_3040; fd[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) commit(1'b1, (i % 2 == 0) ? lb : lc, la);
            write_line(fa[i], (i == 0) ? la : ((i % 2 == 0) ? lb : lc));
            done_chk(fd[i], 1'b1);
        end
        check("rr_idle", 512'(busy), 512'(0));

        // address wrap, then commit with empty FIFO
        accept(0, 32'hFFFF_FFC0, px1);
        commit(1'b0, lc, la);
        write_line(32'hFFFF_FFC0, lc);
        write_line(32'h0000_0000, la);
        done_chk(2'b01, 1'b0);
        check("pre_err", 512'(err), 512'(0));
        commit_valid = 1'b1;
        #1;
        check("empty_crdy", 512'(commit_ready), 512'(0));
        tick();
        commit_valid = 1'b0;
        check("err_set", 512'(err), 512'(1));
        tick();
        check("err_sticky", 512'(err), 512'(1));

        // reset in the middle of the second line write
        accept(1, 32'h0000_4000, px0);
        commit(1'b0, la, lb);
        write_line(32'h0000_4000, la);
        check("l2_addr", 512'(mem_addr), 512'(32'h0000_4040));
        check("l2_wr", 512'(mem_write), 512'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_wr", 512'(mem_write), 512'(0));
        tick();
        rst = 1'b0;
        #1;
        check("rel_wr", 512'(mem_write), 512'(0));
        check("rel_busy", 512'(busy), 512'(0));
        check("rel_done", 512'(done), 512'(0));
        check("rel_err", 512'(err), 512'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_done", 512'(done), 512'(0));
            check("no_wr", 512'(mem_write), 512'(0));
            check("no_crdy", 512'(commit_ready), 512'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/compress_sched.md
COMPRESS_SCHED -- requirements
Module: compress_sched

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the number of blocks allowed between pipeline issue and commit (power of 2, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of the line write port.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  2  per-requester block-available flag.
REQ-006 SHALL have port req_addr  in  2 x ADDR_W  per-requester destination byte address, 64-byte aligned.
REQ-007 SHALL have port req_pixels  in  2 x 1024  per-requester block of 32 RGBA pixels (pixels_t).
REQ-008 SHALL have port req_ready  out  2  per-requester accept strobe.
REQ-009 SHALL have port pipe_in_valid  out  1  block presented to the compression pipeline.
REQ-010 SHALL have port pipe_in_pixels  out  1024  granted requester's pixels.
REQ-011 SHALL have port pipe_in_ready  in  1  pipeline can take a block this cycle.
REQ-012 SHALL have port commit_valid  in  1  commit stage result available.
REQ-013 SHALL have port commit_compressable  in  1  the result fits in one line.
REQ-014 SHALL have port commit_l1  in  512  first output line (line_t).
REQ-015 SHALL have port commit_l2  in  512  second output line (line_t); meaningful only when not compressable.
REQ-016 SHALL have port commit_ready  out  1  scheduler consumes the commit result.
REQ-017 SHALL have port mem_write  out  1  line write request.
REQ-018 SHALL have port mem_addr  out  ADDR_W  write byte address.
REQ-019 SHALL have port mem_wdata  out  512  write line.
REQ-020 SHALL have port mem_resp  in  1  write completed this cycle.
REQ-021 SHALL have port done  out  2  one-cycle per-requester completion pulse.
REQ-022 SHALL have port done_compressed  out  1  valid with done: block was stored as one line.
REQ-023 SHALL have port busy  out  1  blocks are in flight or being written.
REQ-024 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-025 SHALL arbitrate round-robin: with both req_valid high, grant the requester not granted at the last accepted transfer; a lone valid requester is granted.
REQ-026 SHALL drive pipe_in_valid = any req_valid AND inflight count < MAX_INFLIGHT; pipe_in_pixels = granted requester's pixels.
REQ-027 SHALL assert req_ready[g] only for granted g when pipe_in_valid AND pipe_in_ready; a transfer pushes {g, req_addr[g]} into a tag FIFO of depth MAX_INFLIGHT.
REQ-028 SHALL update the round-robin pointer only on a transfer.
REQ-029 SHALL run a write FSM with states IDLE, WR_L1, WR_L2, RESP; commit_ready = (state==IDLE) AND count!=0.
REQ-030 SHALL, on commit_valid AND commit_ready, register l1, l2, compressable, pop the tag FIFO head and go to WR_L1.
REQ-031 SHALL, in WR_L1, hold mem_write=1, mem_addr=tag addr, mem_wdata=l1 until mem_resp; then go to RESP if compressable, else WR_L2.
REQ-032 SHALL, in WR_L2, hold mem_write=1, mem_addr=tag addr+64 (modulo 2^ADDR_W), mem_wdata=l2 until mem_resp; then go to RESP.
REQ-033 SHALL, in RESP, pulse done[tag id] for exactly one cycle with done_compressed=registered compressable, then return to IDLE.
REQ-034 SHALL ignore mem_resp outside WR_L1/WR_L2.
REQ-035 SHALL keep count unchanged on a same-cycle push and pop; pushes never exceed MAX_INFLIGHT, pops never occur at count 0.
REQ-036 SHALL set err when commit_valid is high while count==0; err clears only on reset.
REQ-037 SHALL drive busy = (count!=0) OR (state!=IDLE).
REQ-038 SHALL give a minimum 1 cycle from commit accept to mem_write and 1 cycle from final mem_resp to done.

Reset
REQ-039 SHALL, while rst high, set state IDLE, count 0, FIFO pointers 0, round-robin favouring requester 0, err 0.
REQ-040 SHALL hold req_ready, pipe_in_valid, commit_ready, mem_write, done, done_compressed, busy at 0 during reset and in the cycle after.
REQ-041 SHALL, on reset mid-write, abandon the in-flight line and all tags with no done pulse.

Verification
REQ-042 SHALL cover single compressable block: req0 addr 0x1000, commit compressable=1 -> one write to 0x1000 with l1, then done=2'b01, done_compressed=1.
REQ-043 SHALL cover uncompressable block: req1 addr 0x2040 -> writes at 0x2040 (l1) then 0x2080 (l2), done=2'b10, done_compressed=0.
REQ-044 SHALL cover fairness: both requesters held valid, pipe_in_ready=1 -> accepts alternate 0,1,0,1; done order matches.
REQ-045 SHALL cover full FIFO: 4 accepts, no commits -> pipe_in_valid=0 and req_ready=0 until one commit is accepted.
REQ-046 SHALL cover wrap plus error: addr 0xFFFFFFC0 uncompressable -> second write at 0x00000000; commit_valid with count 0 -> err=1, commit_ready=0.
REQ-047 SHALL cover reset during WR_L2 -> mem_write=0 and busy=0 the cycle after reset deasserts; no done pulse.
